spmv_csr_engine: RTL and testbench

Parametrised CSR sparse matrix-vector engine computing y = A*x for an N_ROWS x N_COLS signed fixed-point matrix held in two external M10K-style read ports. Port A holds the dense vector x and the nonzero values; port B holds row_ptr and col_idx. x is cached internally, then each row's nonzeros are streamed at one per cycle through a multiply-accumulate. Each finished row result is emitted on a valid/ready stream. Adds configurable sizes, base addresses, saturating arithmetic, an error flag and output backpressure.

---
 rtl/spmv_pkg.sv | 11 +
 rtl/spmv_csr_engine_if.sv | 29 ++
 rtl/spmv_mac_unit.sv | 37 +++
 rtl/spmv_csr_engine.sv | 162 ++++++++++++++++
 tb/tb_spmv_csr_engine.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/spmv_pkg.sv
// Shared state encoding and sizing helpers for the CSR sparse matrix-vector engine.
package spmv_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_X, S_RP0, S_ROW, S_MAC, S_WRITE, S_DONE
  } state_t;

  // Index width that stays at least one bit for tiny sizes.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/spmv_csr_engine_if.sv
// Memory read ports (A: x and values, B: row_ptr and col_idx) plus the result stream.
interface spmv_csr_engine_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 10,
  parameter int ROW_W  = 2
);
  logic              a_en;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_en;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              y_valid;
  logic [ROW_W-1:0]  y_row;
  logic [ACC_W-1:0]  y_data;
  logic              y_ready;

  modport master (
    output a_en, a_addr, input a_data,
    output b_en, b_addr, input b_data,
    output y_valid, y_row, y_data, input y_ready
  );
  modport slave (
    input a_en, a_addr, output a_data,
    input b_en, b_addr, output b_data,
    input y_valid, y_row, y_data, output y_ready
  );
endinterface

// File: rtl/spmv_mac_unit.sv
// Signed multiply-accumulate with sign-extended product and optional saturation.
module spmv_mac_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int SAT    = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_x, sum, nxt;
  logic                       ovf;

  always_comb begin
    prod   = a * b;
    prod_x = ACC_W'(prod);
    sum    = acc + prod_x;
    // Overflow only when both addends share a sign the sum does not.
    ovf    = (acc[ACC_W-1] == prod_x[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    nxt    = sum;
    if ((SAT != 0) && ovf) nxt = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)  acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= nxt;
  end
endmodule

// File: rtl/spmv_csr_engine.sv
// CSR y = A*x engine: caches x, walks row_ptr, streams one nonzero per cycle into the MAC.
module spmv_csr_engine
  import spmv_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int N_ROWS   = 4,
  parameter int N_COLS   = 4,
  parameter int ADDR_W   = 10,
  parameter int X_BASE   = 0,
  parameter int VAL_BASE = 64,
  parameter int RP_BASE  = 0,
  parameter int CI_BASE  = 64,
  parameter int SAT      = 0
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_start,
  spmv_csr_engine_if.master bus,
  output logic o_busy,
  output logic o_done,
  output logic o_err
);
  localparam int ROW_W = clog2_min1(N_ROWS);
  localparam int XI_W  = clog2_min1(N_COLS);

  state_t                         state, nxt;
  logic [XI_W:0]                  cnt;
  logic                           phase;
  logic [ROW_W-1:0]               row;
  logic [DATA_W-1:0]              k, start_q, end_q;
  logic                           mac_vld;
  logic                           err;
  logic [N_COLS-1:0][DATA_W-1:0]  x_q;
  logic                           acc_clr, col_ok;
  logic [DATA_W-1:0]              x_sel;
  logic signed [ACC_W-1:0]        acc;

  always_comb begin
    col_ok = bus.b_data < DATA_W'(N_COLS);
    x_sel  = col_ok ? x_q[bus.b_data[XI_W-1:0]] : '0;
  end

  always_comb begin
    nxt        = state;
    acc_clr    = 1'b0;
    bus.a_en   = 1'b0;
    bus.a_addr = '0;
    bus.b_en   = 1'b0;
    bus.b_addr = '0;
    case (state)
      S_IDLE:   if (i_start) nxt = S_LOAD_X;
      S_LOAD_X: begin
        if (cnt == (XI_W+1)'(N_COLS)) nxt = S_RP0;
        else begin
          bus.a_en   = 1'b1;
          bus.a_addr = ADDR_W'(X_BASE) + ADDR_W'(cnt);
        end
      end
      S_RP0: begin
        if (!phase) begin
          bus.b_en   = 1'b1;
          bus.b_addr = ADDR_W'(RP_BASE);
        end else nxt = S_ROW;
      end
      S_ROW: begin
        if (!phase) begin
          bus.b_en   = 1'b1;
          bus.b_addr = ADDR_W'(RP_BASE) + ADDR_W'(row) + ADDR_W'(1);
        end else begin
          acc_clr = 1'b1;
          // Empty or inverted rows skip MAC and emit a zero result.
          nxt = (bus.b_data > start_q) ? S_MAC : S_WRITE;
        end
      end
      S_MAC: begin
        if (k != end_q) begin
          bus.a_en   = 1'b1;
          bus.a_addr = ADDR_W'(VAL_BASE) + ADDR_W'(k);
          bus.b_en   = 1'b1;
          bus.b_addr = ADDR_W'(CI_BASE) + ADDR_W'(k);
        end else nxt = S_WRITE;
      end
      S_WRITE:  if (bus.y_ready) nxt = (row == ROW_W'(N_ROWS-1)) ? S_DONE : S_ROW;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      phase   <= 1'b0;
      row     <= '0;
      k       <= '0;
      start_q <= '0;
      end_q   <= '0;
      mac_vld <= 1'b0;
      err     <= 1'b0;
      x_q     <= '0;
    end else begin
      state   <= nxt;
      mac_vld <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          err   <= 1'b0;
          row   <= '0;
          cnt   <= '0;
          phase <= 1'b0;
        end
        S_LOAD_X: begin
          cnt <= cnt + 1'b1;
          if (cnt != '0) x_q[XI_W'(cnt - 1'b1)] <= bus.a_data;
        end
        S_RP0: begin
          phase <= ~phase;
          if (phase) start_q <= bus.b_data;
        end
        S_ROW: begin
          phase <= ~phase;
          if (phase) begin
            end_q <= bus.b_data;
            k     <= start_q;
            if (bus.b_data < start_q) err <= 1'b1;
          end
        end
        S_MAC: begin
          if (k != end_q) begin
            k       <= k + 1'b1;
            mac_vld <= 1'b1;
          end
          if (mac_vld && !col_ok) err <= 1'b1;
        end
        S_WRITE: if (bus.y_ready) begin
          start_q <= end_q;
          row     <= row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  spmv_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SAT(SAT)) u_mac (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .clr    (acc_clr),
    .en     (mac_vld),
    .a      (bus.a_data),
    .b      (x_sel),
    .acc    (acc)
  );

  always_comb begin
    bus.y_valid = (state == S_WRITE);
    bus.y_row   = bus.y_valid ? row : '0;
    bus.y_data  = bus.y_valid ? acc : '0;
    o_busy      = (state != S_IDLE);
    o_done      = (state == S_DONE);
    o_err       = err;
  end
endmodule

// File: tb/tb_spmv_csr_engine.sv
// Runs a wrap and a saturating engine side by side against a plain-arithmetic CSR model.
module tb_spmv_csr_engine;
  import spmv_pkg::*;
  localparam int DW = 16, AW = 32, NR = 4, NC = 4, ADW = 10, RW = 2;
  localparam int XB = 0, VB = 64, RB = 0, CB = 64;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, ready = 1'b1;
  logic busy0, done0, err0, busy1, done1, err1;
  int   n_chk = 0, n_pass = 0, n_fail = 0;
  logic [DW-1:0] mem_a [0:1023];
  logic [DW-1:0] mem_b [0:1023];
  logic [31:0]   exp_y [2][NR];
  bit            exp_err;

  always #5 clk = ~clk;

  spmv_csr_engine_if #(.DATA_W(DW), .ACC_W(AW), .ADDR_W(ADW), .ROW_W(RW)) bus0 ();
  spmv_csr_engine_if #(.DATA_W(DW), .ACC_W(AW), .ADDR_W(ADW), .ROW_W(RW)) bus1 ();
  assign bus0.y_ready = ready;
  assign bus1.y_ready = ready;

  always @(posedge clk) begin
    if (bus0.a_en) bus0.a_data <= mem_a[bus0.a_addr];
    if (bus0.b_en) bus0.b_data <= mem_b[bus0.b_addr];
    if (bus1.a_en) bus1.a_data <= mem_a[bus1.a_addr];
    if (bus1.b_en) bus1.b_data <= mem_b[bus1.b_addr];
  end

  spmv_csr_engine #(.DATA_W(DW), .ACC_W(AW), .N_ROWS(NR), .N_COLS(NC), .ADDR_W(ADW),
    .X_BASE(XB), .VAL_BASE(VB), .RP_BASE(RB), .CI_BASE(CB), .SAT(0)) dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .bus(bus0.master),
    .o_busy(busy0), .o_done(done0), .o_err(err0));

  spmv_csr_engine #(.DATA_W(DW), .ACC_W(AW), .N_ROWS(NR), .N_COLS(NC), .ADDR_W(ADW),
    .X_BASE(XB), .VAL_BASE(VB), .RP_BASE(RB), .CI_BASE(CB), .SAT(1)) dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .bus(bus1.master),
    .o_busy(busy1), .o_done(done1), .o_err(err1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 1024; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
  endtask

  task automatic set_x(input int x0, input int x1, input int x2, input int x3);
    mem_a[XB] = 16'(x0); mem_a[XB+1] = 16'(x1); mem_a[XB+2] = 16'(x2); mem_a[XB+3] = 16'(x3);
  endtask

  task automatic set_rp(input int r0, input int r1, input int r2, input int r3, input int r4);
    mem_b[RB] = 16'(r0); mem_b[RB+1] = 16'(r1); mem_b[RB+2] = 16'(r2);
    mem_b[RB+3] = 16'(r3); mem_b[RB+4] = 16'(r4);
  endtask

  task automatic set_nz(input int k, input int col, input int val);
    mem_b[CB+k] = 16'(col); mem_a[VB+k] = 16'(val);
  endtask

  // y[r] = sum over row r's nonzeros of value * x[col], from the CSR tables.
  task automatic build_model();
    longint acc, p;
    int s, e, c;
    exp_err = 1'b0;
    for (int sat = 0; sat < 2; sat++) begin
      for (int r = 0; r < NR; r++) begin
        s = int'(mem_b[RB+r]);
        e = int'(mem_b[RB+r+1]);
        if (e < s) exp_err = 1'b1;
        acc = 0;
        for (int k = s; k < e; k++) begin
          c = int'(mem_b[CB+k]);
          if (c >= NC) begin exp_err = 1'b1; p = 0; end
          else p = longint'($signed(mem_a[VB+k])) * longint'($signed(mem_a[XB+c]));
          acc = acc + p;
          if (sat == 1) begin
            if (acc > MAXV) acc = MAXV;
            if (acc < MINV) acc = MINV;
          end else acc = longint'(int'(acc));
        end
        exp_y[sat][r] = acc[31:0];
      end
    end
  endtask

  task automatic run_job(input string nm, input int stall, input bit rnd);
    int got, st;
    bit seen_done;
    build_model();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({nm, ".busy0"}, busy0, 1);
    chk({nm, ".busy1"}, busy1, 1);
    chk({nm, ".errclr0"}, err0, 0);
    chk({nm, ".errclr1"}, err1, 0);
    got = 0; st = 0; seen_done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      @(negedge clk);
      start = (cyc == 8);
      if (done0) begin
        seen_done = 1'b1;
        chk({nm, ".done1"}, done1, 1);
      end
      if (bus0.y_valid && got == 0 && st < stall) begin
        ready = 1'b0;
        st++;
        chk({nm, ".hold_row"}, bus0.y_row, 0);
        chk({nm, ".hold_data0"}, bus0.y_data, exp_y[0][0]);
        chk({nm, ".hold_data1"}, bus1.y_data, exp_y[1][0]);
      end else begin
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus0.y_valid && ready) begin
          if (got < NR) begin
            chk($sformatf("%s.row0[%0d]", nm, got), bus0.y_row, got);
            chk($sformatf("%s.y0[%0d]", nm, got), bus0.y_data, exp_y[0][got]);
            chk($sformatf("%s.vld1[%0d]", nm, got), bus1.y_valid, 1);
            chk($sformatf("%s.row1[%0d]", nm, got), bus1.y_row, got);
            chk($sformatf("%s.y1[%0d]", nm, got), bus1.y_data, exp_y[1][got]);
          end else chk({nm, ".extra_row"}, got, NR - 1);
          got++;
        end
      end
    end
    start = 1'b0;
    ready = 1'b1;
    chk({nm, ".done_seen"}, seen_done, 1);
    chk({nm, ".rows"}, got, NR);
    @(negedge clk);
    chk({nm, ".done_pulse"}, done0, 0);
    chk({nm, ".idle_busy0"}, busy0, 0);
    chk({nm, ".idle_busy1"}, busy1, 0);
    chk({nm, ".idle_vld"}, bus0.y_valid, 0);
    chk({nm, ".err0"}, err0, exp_err);
    chk({nm, ".err1"}, err1, exp_err);
  endtask

  task automatic rand_mat();
    int k, n;
    clr_mem();
    for (int c = 0; c < NC; c++) mem_a[XB+c] = 16'($urandom);
    k = 0;
    for (int r = 0; r < NR; r++) begin
      mem_b[RB+r] = 16'(k);
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        set_nz(k, ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, NC-1)), int'($urandom));
        k++;
      end
    end
    mem_b[RB+NR] = 16'(k);
  endtask

  task automatic set_identity();
    clr_mem();
    set_x(1, 2, 3, 4);
    set_rp(0, 1, 2, 3, 4);
    for (int i = 0; i < 4; i++) set_nz(i, i, 1);
  endtask

  initial begin
    bit found;
    clr_mem();
    repeat (2) @(negedge clk);
    chk("rst.outs0", {bus0.a_en, bus0.b_en, bus0.y_valid, busy0, done0, err0, bus0.y_data}, 0);
    chk("rst.outs1", {bus1.a_en, bus1.b_en, bus1.y_valid, busy1, done1, err1, bus1.y_data}, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle.busy", busy0, 0);

    set_identity();
    run_job("ident", 0, 1'b0);

    set_identity();
    set_rp(0, 2, 2, 3, 4);
    set_nz(0, 0, 2); set_nz(1, 3, -1); set_nz(2, 1, 5); set_nz(3, 2, 3);
    run_job("empty_row", 0, 1'b0);

    clr_mem();
    set_x(-2, 0, 7, 0);
    set_rp(0, 2, 2, 2, 2);
    set_nz(0, 0, -3); set_nz(1, 2, 5);
    run_job("signed", 0, 1'b0);
    chk("signed.model", exp_y[0][0], 32'h0000_0029);

    clr_mem();
    set_x(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF);
    set_rp(0, 3, 3, 3, 3);
    for (int i = 0; i < 3; i++) set_nz(i, i, 32'h7FFF);
    run_job("sat", 0, 1'b0);

    set_identity();
    set_nz(1, 9, 1);
    run_job("badcol", 5, 1'b0);

    clr_mem();
    set_x(3, -4, 5, 6);
    set_rp(0, 2, 1, 3, 3);
    set_nz(0, 0, 1); set_nz(1, 1, 2); set_nz(2, 3, -7);
    run_job("inverted", 0, 1'b1);

    set_identity();
    run_job("errclear", 0, 1'b1);

    for (int j = 0; j < 3; j++) begin
      rand_mat();
      run_job($sformatf("rand%0d", j), 0, 1'b1);
    end

    set_identity();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      @(negedge clk);
      found = bus0.a_en && bus0.b_en;
    end
    chk("midrst.mac_seen", found, 1);
    rstn = 1'b0;
    #1;
    chk("midrst.outs0", {bus0.a_en, bus0.b_en, bus0.y_valid, busy0, done0, err0, bus0.y_data}, 0);
    chk("midrst.outs1", {bus1.a_en, bus1.b_en, bus1.y_valid, busy1, done1, err1, bus1.y_data}, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst.no_partial", {bus0.y_valid, busy0}, 0);
    set_nz(2, 1, 9);
    run_job("after_rst", 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
